// File: rtl/a2d_pkg.sv
// Shared types and command format for the A2D conversion scheduler.
package a2d_pkg;

    typedef enum logic [1:0] {LFT, RGHT, BATT} chan_t;

    typedef enum logic [2:0] {IDLE, CMD, GAP, RD, UPD} state_t;

    localparam logic [1:0]  CMD_PFX = 2'b00;
    localparam logic [10:0] CMD_PAD = 11'h000;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] chn);
        return {CMD_PFX, chn, CMD_PAD};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master, MSB first, SCLK idles high.
// MOSI shifts on SCLK fall, MISO is captured in the first high cycle.
module spi_mstr16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rx,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam int PW = $clog2(SCLK_DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(SCLK_DIV / 2);
    localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);

    logic          act_q, act_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   sh_q, sh_d;
    logic          smp_q, smp_d;
    logic          done_q, done_d;

    always_comb begin
        act_d  = act_q;
        ph_d   = ph_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        smp_d  = smp_q;
        done_d = 1'b0;
        if (wrt) begin
            act_d = 1'b1;
            ph_d  = '0;
            bit_d = '0;
            sh_d  = cmd;
        end else if (act_q) begin
            if (ph_q == PH_RISE) smp_d = MISO;
            if (ph_q == PH_LAST) begin
                ph_d  = '0;
                sh_d  = {sh_q[14:0], smp_q};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    act_d  = 1'b0;
                    done_d = 1'b1;
                end
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q  <= 1'b0;
            ph_q   <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            smp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            ph_q   <= ph_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            smp_q  <= smp_d;
            done_q <= done_d;
        end
    end

    assign SS_n = ~act_q;
    assign SCLK = ~act_q | (ph_q >= PH_RISE);
    assign MOSI = act_q & sh_q[15];
    assign done = done_q;
    assign rx   = sh_q;

endmodule

// File: rtl/a2d_sched.sv
// Round-robin A2D scheduler: each request converts the next channel
// with a command frame followed by a read frame.
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int         SCLK_DIV = 32,
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_BATT  = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_done
);

    state_t      state_q, state_d;
    chan_t       ptr_q, ptr_d, ch_q, ch_d;
    logic        pend_q, pend_d;
    logic        wrt_q, wrt_d;
    logic [11:0] lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
    logic [2:0]  chn;
    logic [15:0] cmd, rx;
    logic        done;
    logic        rx_unused;

    always_comb begin
        unique case (ch_q)
            LFT:     chn = CH_LFT;
            RGHT:    chn = CH_RGHT;
            BATT:    chn = CH_BATT;
            default: chn = CH_LFT;
        endcase
    end

    assign cmd       = a2d_cmd(chn);
    assign rx_unused = ^rx[15:12];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        wrt_d   = 1'b0;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        if (nxt && state_q != IDLE) pend_d = 1'b1;
        unique case (state_q)
            IDLE: if (nxt || pend_q) begin
                ch_d    = ptr_q;
                pend_d  = 1'b0;
                wrt_d   = 1'b1;
                state_d = CMD;
            end
            // second write is registered so it lands in the GAP cycle
            CMD: if (done) begin
                wrt_d   = 1'b1;
                state_d = GAP;
            end
            GAP: state_d = RD;
            RD: if (done) begin
                unique case (ch_q)
                    LFT:     lft_d  = rx[11:0];
                    RGHT:    rght_d = rx[11:0];
                    BATT:    batt_d = rx[11:0];
                    default: lft_d  = lft_q;
                endcase
                state_d = UPD;
            end
            UPD: begin
                unique case (ptr_q)
                    LFT:     ptr_d = RGHT;
                    RGHT:    ptr_d = BATT;
                    default: ptr_d = LFT;
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= LFT;
            ch_q    <= LFT;
            pend_q  <= 1'b0;
            wrt_q   <= 1'b0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'hFFF;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            wrt_q   <= wrt_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
        end
    end

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt_q),
        .cmd  (cmd),
        .MISO (MISO),
        .done (done),
        .rx   (rx),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI)
    );

    assign lft_ld   = lft_q;
    assign rght_ld  = rght_q;
    assign batt     = batt_q;
    assign busy     = (state_q != IDLE);
    assign cnv_done = (state_q == UPD);

endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched with an A2D slave model.
module tb_a2d_sched;

    localparam int D = 4;
    localparam int LAT = 32 * D + 5;

    logic        clk = 1'b0;
    logic        rst, nxt, MISO;
    logic        SS_n, SCLK, MOSI, busy, cnv_done;
    logic [11:0] lft_ld, rght_ld, batt;

    a2d_sched #(.SCLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .nxt      (nxt),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .batt     (batt),
        .busy     (busy),
        .cnv_done (cnv_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    int          nchk = 0;
    int          nfail = 0;
    int          cyc = 0;
    bit          chk_en = 0;
    exp_t        exp_q[$];
    logic [15:0] cmd_q[$];
    exp_t        e_m;
    logic [11:0] reg_m[3];
    int          ptr_m, st_c, end_c;
    bit          act_m, pend_m, exp_busy;

    logic [15:0] cur_resp, mosi_w, last_resp, fix_resp;
    bit          use_fix = 0;
    bit          in_frame = 0;
    int          falls, rises;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ch_cmd(input int ch);
        int n;
        n = (ch == 0) ? 0 : (ch == 1) ? 4 : 5;
        return 16'(n << 11);
    endfunction

    task automatic mreset();
        exp_q.delete();
        cmd_q.delete();
        act_m    = 0;
        pend_m   = 0;
        ptr_m    = 0;
        exp_busy = 0;
        reg_m[0] = 12'h000;
        reg_m[1] = 12'h000;
        reg_m[2] = 12'hFFF;
    endtask

    // Reference model: one conversion occupies cycles S+1..S+LAT,
    // requests during that window collapse into one pending start.
    task automatic step(input bit n);
        bit bsy;
        exp_t e;
        @(posedge clk);
        #1 nxt = n;
        bsy = act_m && cyc > st_c && cyc <= end_c;
        exp_busy = bsy;
        if (!bsy && (n || pend_m)) begin
            act_m  = 1;
            pend_m = 0;
            st_c   = cyc;
            end_c  = cyc + LAT;
            e.ch   = ptr_m;
            e.cyc  = end_c;
            exp_q.push_back(e);
            cmd_q.push_back(ch_cmd(ptr_m));
            cmd_q.push_back(ch_cmd(ptr_m));
            ptr_m = (ptr_m + 1) % 3;
        end else if (bsy && n) begin
            pend_m = 1;
        end
    endtask

    always @(negedge SCLK) begin
        #1;
        if (SS_n === 1'b0 && !rst) begin
            if (!in_frame) begin
                in_frame = 1;
                falls    = 0;
                rises    = 0;
                mosi_w   = 16'h0;
                cur_resp = use_fix ? fix_resp : 16'($urandom);
            end
            if (falls < 16) MISO = cur_resp[15-falls];
            falls++;
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mosi_w = {mosi_w[14:0], MOSI};
            rises++;
        end
    end

    always @(posedge SS_n) begin
        if (!rst && in_frame) begin
            if (cmd_q.size() == 0) chk("unexpected_frame", 0, 1);
            else chk("mosi_cmd", 32'(mosi_w), 32'(cmd_q.pop_front()));
            chk("sclk_rises", rises, 16);
            last_resp = cur_resp;
        end
        in_frame = 0;
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            if (cnv_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cnv_done", 0, 1);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("cnv_cycle", cyc, e_m.cyc);
                    reg_m[e_m.ch] = last_resp[11:0];
                end
            end
            chk("lft_ld", 32'(lft_ld), 32'(reg_m[0]));
            chk("rght_ld", 32'(rght_ld), 32'(reg_m[1]));
            chk("batt", 32'(batt), 32'(reg_m[2]));
        end
    end

    initial begin
        rst  = 1'b1;
        nxt  = 1'b0;
        MISO = 1'b0;
        mreset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        repeat (20) step(0);
        chk("rst_batt", 32'(batt), 32'hFFF);
        chk("rst_lft", 32'(lft_ld), 32'h0);
        chk("rst_ss_n", 32'(SS_n), 32'h1);
        chk("rst_sclk", 32'(SCLK), 32'h1);
        chk("rst_mosi", 32'(MOSI), 32'h0);
        chk("rst_cnv", 32'(cnv_done), 32'h0);

        use_fix  = 1;
        fix_resp = 16'h0ABC;
        step(1);
        repeat (150) step(0);
        chk("single_lft", 32'(lft_ld), 32'hABC);
        chk("single_rght", 32'(rght_ld), 32'h0);
        chk("single_batt", 32'(batt), 32'hFFF);
        use_fix = 0;

        for (int k = 0; k < 4; k++) begin
            step(1);
            repeat (199) step(0);
        end

        step(1);
        repeat (10) step(0);
        step(1);
        repeat (40) step(0);
        step(1);
        repeat (50) step(0);
        step(1);
        repeat (400) step(0);

        step(1);
        repeat (LAT - 1) step(0);
        step(1);
        repeat (300) step(0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 200)) step(0);
            step(1);
        end
        repeat (400) step(0);

        while (ptr_m == 0) begin
            step(1);
            repeat (150) step(0);
        end
        step(1);
        repeat (99) step(0);
        @(posedge clk);
        #1 rst = 1'b1;
        mreset();
        #1;
        chk("abort_ss_n", 32'(SS_n), 32'h1);
        chk("abort_sclk", 32'(SCLK), 32'h1);
        chk("abort_mosi", 32'(MOSI), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_lft", 32'(lft_ld), 32'h0);
        chk("abort_rght", 32'(rght_ld), 32'h0);
        chk("abort_batt", 32'(batt), 32'hFFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) step(0);
        step(1);
        repeat (300) step(0);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("cmd_q_empty", cmd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
